// File: rtl/ss_scan_driver.sv
// Scans four active-low seven-segment patterns onto a shared bus. Outputs are registered with 1 cycle of latency and there is no backpressure.
// Frame-start shadowing stops tearing. A blanking guard opens each slot. Defining SS_BRIGHTNESS_EN adds a 3-bit PWM brightness input.
module ss_scan_driver #(
    parameter int REFRESH_DIV  = 25000,
    parameter int BLANK_CYCLES = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg3,
    input  logic [6:0] seg2,
    input  logic [6:0] seg1,
    input  logic [6:0] seg0,
    input  logic [3:0] digit_en,
`ifdef SS_BRIGHTNESS_EN
    input  logic [2:0] brightness,
`endif
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_tick
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

    logic [CW-1:0] div_q, div_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    shadow_q [4];
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          tick_q, tick_d;
    logic          slot_end;
    logic          frame_start;
    logic          lit;

`ifdef SS_BRIGHTNESS_EN
    // Zero-extend so the PWM phase is defined even for very short slots.
    logic [CW+2:0] div_ext;
    logic [2:0]    pwm_phase;
    assign div_ext   = {3'b000, div_q};
    assign pwm_phase = div_ext[2:0];
`endif

    always_comb begin
        slot_end    = (div_q == DIV_LAST);
        frame_start = (div_q == '0) && (idx_q == 2'd0);
        div_d       = slot_end ? '0 : div_q + 1'b1;
        idx_d       = slot_end ? idx_q + 2'd1 : idx_q;
        tick_d      = slot_end && (idx_q == 2'd3);

        lit = (div_q >= BLANK_LIM) && digit_en[idx_q];
`ifdef SS_BRIGHTNESS_EN
        lit = lit && (pwm_phase <= brightness);
`endif

        an_d  = 4'b1111;
        seg_d = 7'h7F;
        if (lit) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = shadow_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            idx_q  <= 2'd0;
            an_q   <= 4'b1111;
            seg_q  <= 7'h7F;
            tick_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= 7'h7F;
            end
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            tick_q <= tick_d;
            // The new shadow value is seen only by decisions made after this cycle.
            if (frame_start) begin
                shadow_q[0] <= seg0;
                shadow_q[1] <= seg1;
                shadow_q[2] <= seg2;
                shadow_q[3] <= seg3;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_ss_scan_driver.sv
// Directed bench for ss_scan_driver with REFRESH_DIV=8 and BLANK_CYCLES=2.
module tb_ss_scan_driver;

    logic       clk;
    logic       rst;
    logic [6:0] seg3, seg2, seg1, seg0;
    logic [3:0] digit_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_tick;
`ifdef SS_BRIGHTNESS_EN
    logic [2:0] brightness;
`endif

    int compared   = 0;
    int mismatched = 0;
    int br         = 7;

    ss_scan_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg3       (seg3),
        .seg2       (seg2),
        .seg1       (seg1),
        .seg0       (seg0),
        .digit_en   (digit_en),
`ifdef SS_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int c, input logic [11:0] obs, input logic [11:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s c=%0d: got an/seg/tick=%h want %h", tag, c, obs, exp);
        end
    endtask

    // Expected {an, seg, frame_tick} for output cycle c (1 = first cycle after reset release).
    function automatic logic [11:0] exp_vec(input int c, input logic [3:0] en,
                                            input logic [27:0] pats, input int bright);
        int         p;
        int         dg;
        int         d;
        logic [3:0] a;
        logic [6:0] s;
        logic       t;
        p  = (c - 1) % 32;
        dg = p / 8;
        d  = p % 8;
        a  = 4'hF;
        s  = 7'h7F;
        t  = (p == 31);
        if (d >= 2 && en[dg] && d <= bright) begin
            a = ~(4'b0001 << dg);
            s = pats[dg*7 +: 7];
        end
        return {a, s, t};
    endfunction

    initial begin
        logic [27:0] pats;
        rst      = 1'b1;
        seg0     = 7'h40;
        seg1     = 7'h79;
        seg2     = 7'h24;
        seg3     = 7'h30;
        digit_en = 4'hF;
`ifdef SS_BRIGHTNESS_EN
        brightness = 3'd7;
`endif

        for (int k = 1; k <= 3; k++) begin
            step();
            chk("reset", k, {an, seg, frame_tick}, 12'hFFE);
        end
        rst = 1'b0;

        // Frame 1; seg1 changes mid-frame and must stay hidden until frame 2.
        pats = {7'h30, 7'h24, 7'h79, 7'h40};
        for (int c = 1; c <= 32; c++) begin
            step();
            chk("scan_f1", c, {an, seg, frame_tick}, exp_vec(c, 4'hF, pats, br));
            if (c == 14) seg1 = 7'h12;
        end

        pats = {7'h30, 7'h24, 7'h12, 7'h40};
        for (int c = 33; c <= 64; c++) begin
            step();
            chk("tear_f2", c, {an, seg, frame_tick}, exp_vec(c, 4'hF, pats, br));
        end

        digit_en = 4'b1011;
        for (int c = 65; c <= 96; c++) begin
            step();
            chk("mask_f3", c, {an, seg, frame_tick}, exp_vec(c, 4'b1011, pats, br));
        end

        // Reset arrives in the middle of the digit-2 drive phase.
        digit_en = 4'hF;
        for (int c = 97; c <= 116; c++) begin
            step();
            chk("pre_rst", c, {an, seg, frame_tick}, exp_vec(c, 4'hF, pats, br));
        end
        rst = 1'b1;
        step();
        chk("mid_rst", 0, {an, seg, frame_tick}, 12'hFFE);
        rst = 1'b0;

        for (int c = 1; c <= 8; c++) begin
            step();
            chk("post_rst", c, {an, seg, frame_tick}, exp_vec(c, 4'hF, pats, br));
        end

`ifdef SS_BRIGHTNESS_EN
        brightness = 3'd0;
        br         = 0;
`endif
        for (int c = 9; c <= 32; c++) begin
            step();
            chk("bright", c, {an, seg, frame_tick}, exp_vec(c, 4'hF, pats, br));
        end
`ifdef SS_BRIGHTNESS_EN
        brightness = 3'd7;
        br         = 7;
`endif
        for (int c = 33; c <= 40; c++) begin
            step();
            chk("bright_full", c, {an, seg, frame_tick}, exp_vec(c, 4'hF, pats, br));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ss_scan_driver.md
Name: ss_scan_driver

Overview:
- Time-multiplexed 4-digit seven-segment driver, the display end of the decoder interface.
- Takes the four active-low segment patterns seg3..seg0 and scans them onto a shared segment bus with active-low digit anodes.
- Holds input patterns in a frame-boundary shadow register so a frame never mixes old and new digits (no tearing).
- Inserts a blanking guard at the start of each digit slot to suppress ghosting.

Parameters:
- REFRESH_DIV, 25000: clk cycles per digit slot; 1 kHz digit rate at 25 MHz. Legal range ≥ 2.
- BLANK_CYCLES, 250: cycles at the start of each slot with all anodes off. Must be < REFRESH_DIV; 0 is legal.

Ports:
- clk  input  1  25 MHz clock.
- rst  input  1  reset, synchronous, active-high.
- seg3  input  7  active-low pattern, leftmost digit.
- seg2  input  7  active-low pattern, digit 2.
- seg1  input  7  active-low pattern, digit 1.
- seg0  input  7  active-low pattern, rightmost digit.
- digit_en  input  4  per-digit enable; bit i = 0 keeps anode i off.
- an  output  4  active-low anodes; an[0] is the rightmost digit.
- seg  output  7  active-low shared segment bus.
- frame_tick  output  1  one-cycle pulse at the end of each 4-digit frame.

Behaviour:
- Counters:
  - div_cnt counts 0..REFRESH_DIV-1; width $clog2(REFRESH_DIV).
  - idx counts 0..3 and advances when div_cnt == REFRESH_DIV-1. Scan order 0,1,2,3, then wraps 3→0.
- Shadow register:
  - Loads all four seg inputs on any cycle with div_cnt==0 && idx==0, not in reset.
  - This includes the first cycle after reset release.
  - Input changes at any other time are invisible until the next frame start.
- Slot phases, decided from (div_cnt, idx):
  - BLANK (div_cnt < BLANK_CYCLES): an=4'b1111, seg=7'h7F.
  - DRIVE (div_cnt ≥ BLANK_CYCLES): an has bit idx low and all other bits high; seg=shadow[idx].
  - If digit_en[idx]==0 in DRIVE: an=4'b1111 and seg=7'h7F. Slot timing is unchanged.
- frame_tick:
  - Asserted for one cycle when idx==3 && div_cnt==REFRESH_DIV-1.
- Output timing:
  - an, seg and frame_tick are registered and glitch-free.
  - They lag the (div_cnt, idx) state that produced them by exactly 1 cycle.
  - Shadow data loaded at state cycle t is usable by the decision made at t+1.
- digit_en is sampled live (not shadowed); it takes effect via the 1-cycle output register.
- Reset, while rst is high:
  - div_cnt=0, idx=0, shadow=7'h7F×4, an=4'b1111, seg=7'h7F, frame_tick=0.
  - Reset mid-scan aborts the slot immediately.
  - Outputs are blank on the cycle after rst is sampled high.
  - The scan restarts at digit 0, slot start, on release.
- Simultaneous events: a frame-start shadow load and digit_en changes in the same cycle are both honoured. There are no other event collisions.

Optional Feature:
- Macro: SS_BRIGHTNESS_EN.
- Defined:
  - Adds input port brightness [2:0].
  - In DRIVE, the digit is lit only when div_cnt[2:0] ≤ brightness; otherwise outputs are blanked (an=4'b1111, seg=7'h7F).
  - This gives 8-level PWM at clk/8. brightness=7 is identical to the feature-off behaviour.
- Undefined: no brightness port; the digit is lit for the whole DRIVE phase.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2; cycle numbers are output cycles after rst release, including the 1-cycle lag):
- Reset: rst high 3 cycles with nonzero seg inputs → an=4'b1111, seg=7'h7F, frame_tick=0 throughout.
- Basic scan: seg0=7'h40, seg1=7'h79, seg2=7'h24, seg3=7'h30, digit_en=4'hF → expected outputs:
  - cycles 1-2: blank.
  - cycles 3-8: an=4'b1110, seg=7'h40.
  - cycles 11-16: an=4'b1101, seg=7'h79.
  - cycles 19-24: an=4'b1011, seg=7'h24.
  - cycles 27-32: an=4'b0111, seg=7'h30.
  - frame_tick high only at cycle 32.
- Tearing: change seg1 to 7'h12 at cycle 14 → digit 1 still shows 7'h79 in frame 1; shows 7'h12 in frame 2 (cycles 43-48).
- Enable mask: digit_en=4'b1011 → digit-2 slot stays an=4'b1111, seg=7'h7F; other slots and frame_tick timing unchanged.
- Mid-scan reset: assert rst for 1 cycle during the digit-2 DRIVE phase → blank on the next cycle; after release the digit-0 pattern reappears 3 cycles later.
- SS_BRIGHTNESS_EN, brightness=3'd0 → in each DRIVE phase the digit is lit only on cycles where div_cnt[2:0]==0, i.e. never for BLANK_CYCLES=2, REFRESH_DIV=8. Rerun with brightness=3'd7 → matches the basic scan exactly.
